shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one combinational shift unit between NUM_REQ_P independent requesters, e.g. the Sobel magnitude/normalisation stages.
- Each requester presents {data, shamt, op} on a valid/ready handshake.
- A round-robin arbiter grants at most one request per cycle and drives the shared shifter.
- The result is captured in a single registered response slot, tagged with the requester id, and drained on a valid/ready handshake.

Parameters:
- NUM_REQ_P, 4, number of requesters (>=2).
- WIDTH_P, 32, data width.
- SHAMT_WIDTH_P, $clog2(WIDTH_P), shift-amount width.
- ID_WIDTH_P, $clog2(NUM_REQ_P), requester id width.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset, asynchronous, active-low.
- req_valid_i  input  NUM_REQ_P  per-requester request valid.
- req_ready_o  output  NUM_REQ_P  per-requester grant/accept, one-hot or zero.
- req_data_i  input  NUM_REQ_P*WIDTH_P  flattened operands; requester k occupies bits [k*WIDTH_P +: WIDTH_P].
- req_shamt_i  input  NUM_REQ_P*SHAMT_WIDTH_P  flattened shift amounts.
- req_op_i  input  NUM_REQ_P*2  flattened ops: 00 SLL, 01 SRL, 10 SRA, 11 reserved.
- resp_valid_o  output  1  response slot full.
- resp_ready_i  input  1  consumer accepts the response.
- resp_data_o  output  WIDTH_P  shift result.
- resp_id_o  output  ID_WIDTH_P  index of the requester that produced the result.
- resp_op_err_o  output  1  the request used reserved op 11.

Behaviour:
- Reset (async, rst_ni=0): resp_valid_o=0, resp_data_o=0, resp_id_o=0, resp_op_err_o=0, and the round-robin pointer is 0, so requester 0 has highest priority.
- Accept condition: can_accept = !resp_valid_o || resp_ready_i. Full throughput is one result per cycle while the consumer keeps resp_ready_i=1.
- Grant rules:
  - Only when can_accept is 1, grant the first asserted req_valid_i searching upward from the pointer, wrapping from NUM_REQ_P-1 to 0.
  - req_ready_o is purely combinational: it is 1 only for the granted index.
  - req_ready_o must not depend on req_data_i, req_shamt_i or req_op_i.
- Pointer update: on a grant to index g, the pointer becomes (g+1) mod NUM_REQ_P. With no grant, the pointer holds. This guarantees each waiting requester is served within NUM_REQ_P grants.
- Datapath and latency:
  - The granted operands are muxed into one shift instance.
  - The result, id and op_err=(op==11) are registered at the clock edge of the grant. Latency is 1 cycle, grant to resp_valid_o.
  - Op 11 passes data through unshifted and sets resp_op_err_o=1.
- Output register behaviour:
  - Holds stable while resp_valid_o=1 and resp_ready_i=0.
  - Drain and refill in the same cycle: a new result loads and resp_valid_o stays 1.
  - Drain with no grant: resp_valid_o falls to 0.
- No request: the output slot is unchanged and req_ready_o is all zero.
- Requester obligations: once req_valid_i is asserted, its operands must stay stable until ready. Dropping valid before a grant is permitted; the arbiter simply skips that requester.
- Shift semantics: SLL, SRL and SRA over WIDTH_P bits, with shamt in 0..WIDTH_P-1. SRA replicates bit WIDTH_P-1.
- Reset asserted mid-transfer: the pending response is discarded immediately and no stale response appears after release.

Decomposition:
- Package shift_pkg holds the shift_op_e enum (SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b10, SHIFT_RSVD=2'b11) and OP_WIDTH=2. Both the shifter and this block import it.
- Sub-module rr_arbiter (parameter N) provides req, enable in, one-hot grant, and the grant index out. It also owns the pointer register (clk_i/rst_ni).
- The existing shift module is instantiated once as the shared datapath.

Test Plan:
- Single SRA: req0 data=0x80000001, shamt=4, op=10, resp_ready_i=1 -> req_ready_o=0001 in the same cycle; next cycle resp_valid_o=1, resp_data_o=0xF8000000, resp_id_o=0, resp_op_err_o=0.
- Fairness: all four req_valid_i held high, resp_ready_i=1 -> grants 0,1,2,3,0,1 on consecutive cycles, and resp_id_o follows one cycle later.
- Backpressure: slot full and resp_ready_i=0 for 5 cycles with req2 pending -> req_ready_o=0000 and resp_data_o/resp_id_o stable. When resp_ready_i=1, req2 is granted that same cycle and its result appears the next cycle.
- Reserved op: req1 data=0x00001234, op=11 -> resp_data_o=0x00001234, resp_op_err_o=1, resp_id_o=1.
- Boundary shifts: SRL 0xFFFFFFFF by 31 -> 0x00000001. SLL 0x00000001 by 31 -> 0x80000000. SRA 0x7FFFFFFF by 0 -> 0x7FFFFFFF.
- Reset mid-op: with resp_valid_o=1 and the pointer at 3, pulse rst_ni low off-edge -> resp_valid_o=0 immediately. After release, simultaneous req0 and req3 grant req0 first.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the shift datapath and the request arbiter in front of it.
package shift_pkg;

    localparam int OP_WIDTH = 2;

    typedef enum logic [OP_WIDTH-1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_RSVD = 2'b11
    } shift_op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches upward from a rotating pointer, wrapping at N-1.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = $clog2(N)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic [N-1:0]   req_i,
    input  logic           en_i,
    output logic [N-1:0]   grant_o,
    output logic [IDW-1:0] grant_idx_o,
    output logic           grant_valid_o
);

    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] ptr_next;
    logic           found;
    logic [IDW-1:0] idx;

    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            cand = (int'(ptr_reg) + i) % N;
            if (!found && req_i[cand]) begin
                found = 1'b1;
                idx   = IDW'(cand);
            end
        end
    end

    assign grant_valid_o = found && en_i;
    assign grant_idx_o   = idx;

    for (genvar gi = 0; gi < N; gi++) begin : g_grant
        assign grant_o[gi] = grant_valid_o && (idx == IDW'(gi));
    end

    // The winner drops to lowest priority; with no grant the pointer holds.
    always_comb begin
        ptr_next = ptr_reg;
        if (grant_valid_o) begin
            ptr_next = (idx == IDW'(N - 1)) ? '0 : idx + IDW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/shift.sv
// Combinational barrel shifter: logical left/right and arithmetic right.
module shift
    import shift_pkg::*;
#(
    parameter int WIDTH_P       = 32,
    parameter int SHAMT_WIDTH_P = $clog2(WIDTH_P)
) (
    input  logic [WIDTH_P-1:0]       data_i,
    input  logic [SHAMT_WIDTH_P-1:0] shamt_i,
    input  logic [OP_WIDTH-1:0]      op_i,
    output logic [WIDTH_P-1:0]       result_o,
    output logic                     op_err_o
);

    always_comb begin
        result_o = data_i;
        op_err_o = 1'b0;
        case (shift_op_e'(op_i))
            SHIFT_SLL: result_o = data_i << shamt_i;
            SHIFT_SRL: result_o = data_i >> shamt_i;
            SHIFT_SRA: result_o = $signed(data_i) >>> shamt_i;
            // Reserved op passes the operand through and is flagged.
            default:   op_err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Shares one shift unit between NUM_REQ_P requesters; results land in a single
// registered response slot tagged with the requester id.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NUM_REQ_P     = 4,
    parameter int WIDTH_P       = 32,
    parameter int SHAMT_WIDTH_P = $clog2(WIDTH_P),
    parameter int ID_WIDTH_P    = $clog2(NUM_REQ_P)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_REQ_P-1:0]               req_valid_i,
    output logic [NUM_REQ_P-1:0]               req_ready_o,
    input  logic [NUM_REQ_P*WIDTH_P-1:0]       req_data_i,
    input  logic [NUM_REQ_P*SHAMT_WIDTH_P-1:0] req_shamt_i,
    input  logic [NUM_REQ_P*OP_WIDTH-1:0]      req_op_i,
    output logic                               resp_valid_o,
    input  logic                               resp_ready_i,
    output logic [WIDTH_P-1:0]                 resp_data_o,
    output logic [ID_WIDTH_P-1:0]              resp_id_o,
    output logic                               resp_op_err_o
);

    logic [WIDTH_P-1:0]       data_arr  [NUM_REQ_P];
    logic [SHAMT_WIDTH_P-1:0] shamt_arr [NUM_REQ_P];
    logic [OP_WIDTH-1:0]      op_arr    [NUM_REQ_P];

    for (genvar gi = 0; gi < NUM_REQ_P; gi++) begin : g_unpack
        assign data_arr[gi]  = req_data_i[gi*WIDTH_P +: WIDTH_P];
        assign shamt_arr[gi] = req_shamt_i[gi*SHAMT_WIDTH_P +: SHAMT_WIDTH_P];
        assign op_arr[gi]    = req_op_i[gi*OP_WIDTH +: OP_WIDTH];
    end

    logic                  resp_valid_reg;
    logic [WIDTH_P-1:0]    resp_data_reg;
    logic [ID_WIDTH_P-1:0] resp_id_reg;
    logic                  resp_op_err_reg;

    logic                  can_accept;
    logic                  grant_valid;
    logic [ID_WIDTH_P-1:0] grant_idx;

    // Slot is free, or is being drained this very cycle.
    assign can_accept = !resp_valid_reg || resp_ready_i;

    rr_arbiter #(
        .N   (NUM_REQ_P),
        .IDW (ID_WIDTH_P)
    ) u_arb (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_i         (req_valid_i),
        .en_i          (can_accept),
        .grant_o       (req_ready_o),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid)
    );

    logic [WIDTH_P-1:0] shift_result;
    logic               shift_op_err;

    shift #(
        .WIDTH_P       (WIDTH_P),
        .SHAMT_WIDTH_P (SHAMT_WIDTH_P)
    ) u_shift (
        .data_i   (data_arr[grant_idx]),
        .shamt_i  (shamt_arr[grant_idx]),
        .op_i     (op_arr[grant_idx]),
        .result_o (shift_result),
        .op_err_o (shift_op_err)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_valid_reg  <= 1'b0;
            resp_data_reg   <= '0;
            resp_id_reg     <= '0;
            resp_op_err_reg <= 1'b0;
        end else if (grant_valid) begin
            resp_valid_reg  <= 1'b1;
            resp_data_reg   <= shift_result;
            resp_id_reg     <= grant_idx;
            resp_op_err_reg <= shift_op_err;
        end else if (resp_ready_i) begin
            resp_valid_reg  <= 1'b0;
        end
    end

    assign resp_valid_o  = resp_valid_reg;
    assign resp_data_o   = resp_data_reg;
    assign resp_id_o     = resp_id_reg;
    assign resp_op_err_o = resp_op_err_reg;

endmodule

// File: tb/tb_shift_arbiter.sv
// Scoreboard bench for shift_arbiter: a reference arbiter/slot model predicts
// grants and queues expected responses, compared when the slot is observed.
module tb_shift_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int SW = 5;
    localparam int IW = 2;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_data_flat;
    logic [N*SW-1:0]  req_shamt_flat;
    logic [N*2-1:0]   req_op_flat;
    logic             resp_valid;
    logic             resp_ready;
    logic [W-1:0]     resp_data;
    logic [IW-1:0]    resp_id;
    logic             resp_op_err;

    logic [W-1:0]     rd [N];
    logic [SW-1:0]    rs [N];
    logic [1:0]       ro [N];

    shift_arbiter #(
        .NUM_REQ_P     (N),
        .WIDTH_P       (W),
        .SHAMT_WIDTH_P (SW),
        .ID_WIDTH_P    (IW)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_data_i    (req_data_flat),
        .req_shamt_i   (req_shamt_flat),
        .req_op_i      (req_op_flat),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_data_o   (resp_data),
        .resp_id_o     (resp_id),
        .resp_op_err_o (resp_op_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_data_flat  = '0;
        req_shamt_flat = '0;
        req_op_flat    = '0;
        for (int k = 0; k < N; k++) begin
            req_data_flat[k*W +: W]    = rd[k];
            req_shamt_flat[k*SW +: SW] = rs[k];
            req_op_flat[k*2 +: 2]      = ro[k];
        end
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [SW-1:0] s,
                                               input logic [1:0] o);
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return W'($signed(d) >>> s);
            default: return d;
        endcase
    endfunction

    typedef struct packed {
        logic [IW-1:0] id;
        logic [W-1:0]  data;
        logic          err;
    } exp_t;

    exp_t         sb[$];
    logic [IW-1:0] m_ptr;
    logic          m_valid;
    logic [N-1:0]  last_gnt;
    logic          auto_drop;

    task automatic model_reset();
        m_ptr    = '0;
        m_valid  = 1'b0;
        last_gnt = '0;
        sb.delete();
    endtask

    // Reference model evaluated with inputs settled, ahead of the next edge.
    always @(negedge clk) begin
        if (rst_n) begin
            logic         can;
            logic         found;
            int           g;
            logic [N-1:0] exp_gnt;
            exp_t         e;
            can     = !m_valid || resp_ready;
            found   = 1'b0;
            g       = 0;
            exp_gnt = '0;
            for (int i = 0; i < N; i++) begin
                int c;
                c = (int'(m_ptr) + i) % N;
                if (can && !found && req_valid[c]) begin
                    found = 1'b1;
                    g     = c;
                end
            end
            if (found) exp_gnt[g] = 1'b1;
            check_val("req_ready", 64'(req_ready), 64'(exp_gnt));
            check_val("resp_valid", 64'(resp_valid), 64'(m_valid));
            if (m_valid) begin
                if (sb.size() == 0) begin
                    check_val("sb_empty", 64'(sb.size()), 64'd1);
                end else begin
                    e = sb[0];
                    check_val("resp_data", 64'(resp_data), 64'(e.data));
                    check_val("resp_id", 64'(resp_id), 64'(e.id));
                    check_val("resp_err", 64'(resp_op_err), 64'(e.err));
                    if (resp_ready) begin
                        $display("resp id=%0d data=%08h err=%0b", resp_id, resp_data, resp_op_err);
                        void'(sb.pop_front());
                    end
                end
            end
            if (found) begin
                e.id   = IW'(g);
                e.data = ref_shift(rd[g], rs[g], ro[g]);
                e.err  = (ro[g] == 2'b11);
                sb.push_back(e);
                m_ptr   = IW'((g + 1) % N);
                m_valid = 1'b1;
            end else if (resp_ready) begin
                m_valid = 1'b0;
            end
            last_gnt = req_ready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_drop) req_valid = req_valid & ~last_gnt;
        last_gnt = '0;
    endtask

    task automatic set_req(input int k, input logic [W-1:0] d, input logic [SW-1:0] s,
                           input logic [1:0] o);
        rd[k] = d;
        rs[k] = s;
        ro[k] = o;
        req_valid[k] = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        req_valid  = '0;
        resp_ready = 1'b1;
        auto_drop  = 1'b1;
        for (int k = 0; k < N; k++) begin
            rd[k] = '0;
            rs[k] = '0;
            ro[k] = '0;
        end
        do_reset();

        // Reset state
        @(negedge clk);
        check_val("rst_valid", 64'(resp_valid), 64'd0);
        check_val("rst_data", 64'(resp_data), 64'd0);
        check_val("rst_id", 64'(resp_id), 64'd0);
        check_val("rst_err", 64'(resp_op_err), 64'd0);

        // Single SRA on requester 0
        tick();
        set_req(0, 32'h8000_0001, 5'd4, 2'b10);
        @(negedge clk);
        check_val("sra_grant", 64'(req_ready), 64'b0001);
        tick();
        @(negedge clk);
        check_val("sra_data", 64'(resp_data), 64'hF800_0000);
        check_val("sra_id", 64'(resp_id), 64'd0);

        // Fairness from a fresh pointer with all requesters held valid
        do_reset();
        auto_drop = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 32'h1000_0000 * (k + 1), SW'(k), 2'b01);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val($sformatf("fair_grant%0d", i), 64'(req_ready), 64'(1 << (i % N)));
            if (i > 0) check_val($sformatf("fair_id%0d", i), 64'(resp_id), 64'((i - 1) % N));
            tick();
        end
        req_valid  = '0;
        resp_ready = 1'b0;
        auto_drop  = 1'b1;

        // Backpressure: slot holds id 1 while requester 2 waits
        set_req(2, 32'hCAFE_F00D, 5'd8, 2'b00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_val("bp_ready", 64'(req_ready), 64'b0000);
            check_val("bp_id", 64'(resp_id), 64'd1);
            tick();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check_val("bp_release", 64'(req_ready), 64'b0100);
        tick();
        @(negedge clk);
        check_val("bp_id2", 64'(resp_id), 64'd2);
        check_val("bp_data2", 64'(resp_data), 64'hFEF0_0D00);

        // Reserved op passes data through and flags the error
        tick();
        set_req(1, 32'h0000_1234, 5'd5, 2'b11);
        @(negedge clk);
        tick();
        @(negedge clk);
        check_val("rsvd_data", 64'(resp_data), 64'h0000_1234);
        check_val("rsvd_err", 64'(resp_op_err), 64'd1);
        check_val("rsvd_id", 64'(resp_id), 64'd1);

        // Boundary shift amounts
        tick();
        set_req(3, 32'hFFFF_FFFF, 5'd31, 2'b01);
        @(negedge clk);
        tick();
        @(negedge clk);
        check_val("srl31", 64'(resp_data), 64'h0000_0001);
        set_req(3, 32'h0000_0001, 5'd31, 2'b00);
        @(negedge clk);
        tick();
        @(negedge clk);
        check_val("sll31", 64'(resp_data), 64'h8000_0000);
        set_req(3, 32'h7FFF_FFFF, 5'd0, 2'b10);
        @(negedge clk);
        tick();
        @(negedge clk);
        check_val("sra0", 64'(resp_data), 64'h7FFF_FFFF);

        // Random traffic with random backpressure
        for (int c = 0; c < 300; c++) begin
            tick();
            for (int k = 0; k < N; k++) begin
                if (!req_valid[k] && $urandom_range(0, 2) == 0) begin
                    set_req(k, $urandom, SW'($urandom_range(0, W - 1)), 2'($urandom_range(0, 3)));
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
        end
        tick();
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (3) tick();

        // Reset mid-transfer with the pointer parked at 3
        resp_ready = 1'b0;
        set_req(2, 32'h0000_00F0, 5'd4, 2'b01);
        @(negedge clk);
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_val("mid_rst_valid", 64'(resp_valid), 64'd0);
        check_val("mid_rst_data", 64'(resp_data), 64'd0);
        req_valid = '0;
        @(posedge clk);
        #3;
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        set_req(0, 32'h0000_0003, 5'd1, 2'b00);
        set_req(3, 32'h0000_0030, 5'd1, 2'b01);
        @(negedge clk);
        check_val("post_rst_grant0", 64'(req_ready), 64'b0001);
        tick();
        @(negedge clk);
        check_val("post_rst_grant3", 64'(req_ready), 64'b1000);
        check_val("post_rst_data0", 64'(resp_data), 64'h0000_0006);
        tick();
        @(negedge clk);
        check_val("post_rst_id3", 64'(resp_id), 64'd3);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
